// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// one registered response slot per requester with valid/ready backpressure.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] rsp_busy;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       last_grant_reg;   // 1 = requester 1 was granted most recently
    logic       err_next;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign rsp_busy  = {g_rsp[1].valid_reg, g_rsp[0].valid_reg};

    // A requester may issue only if its response slot is free or draining now.
    assign elig = req_valid & (~rsp_busy | rsp_ready);

    always_comb begin
        grant = 2'b00;
        if (reset) begin
            if (elig == 2'b11)
                grant = last_grant_reg ? 2'b01 : 2'b10;
            else
                grant = elig;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = 4'h0;
        if (grant[0]) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
        end else if (grant[1]) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    assign err_next = !op_legal(alu_ctrl);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant_reg <= 1'b1;
        else if (grant != 2'b00)
            last_grant_reg <= grant[1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            logic             valid_reg;
            logic [WIDTH-1:0] result_reg;
            logic             zero_reg;
            logic             err_reg;

            // A fresh grant reloads the slot even in the cycle it is consumed.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg  <= 1'b0;
                    result_reg <= '0;
                    zero_reg   <= 1'b0;
                    err_reg    <= 1'b0;
                end else if (grant[gi]) begin
                    valid_reg  <= 1'b1;
                    result_reg <= alu_result;
                    zero_reg   <= alu_zero;
                    err_reg    <= err_next;
                end else if (rsp_ready[gi]) begin
                    valid_reg  <= 1'b0;
                end
            end
        end
    endgenerate

    assign rsp0_valid  = g_rsp[0].valid_reg;
    assign rsp0_result = g_rsp[0].result_reg;
    assign rsp0_zero   = g_rsp[0].zero_reg;
    assign rsp0_err    = g_rsp[0].err_reg;
    assign rsp1_valid  = g_rsp[1].valid_reg;
    assign rsp1_result = g_rsp[1].result_reg;
    assign rsp1_zero   = g_rsp[1].zero_reg;
    assign rsp1_err    = g_rsp[1].err_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width; ALU op code fixed at 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  (N=0,1) operation accepted this cycle.
REQ-006 reqN_a, reqN_b  in  WIDTH  (N=0,1) operands.
REQ-007 reqN_op  in  4  (N=0,1) ALU control code.
REQ-008 rspN_valid  out  1  (N=0,1) response register N holds a result.
REQ-009 rspN_ready  in  1  (N=0,1) requester N consumes its response.
REQ-010 rspN_result  out  WIDTH  (N=0,1) registered ALU result.
REQ-011 rspN_zero  out  1  (N=0,1) registered zero flag.
REQ-012 rspN_err  out  1  (N=0,1) registered illegal-op flag.
REQ-013 alu_a, alu_b  out  WIDTH  operands to the shared combinational ALU.
REQ-014 alu_ctrl  out  4  ALU control to the shared ALU.
REQ-015 alu_result  in  WIDTH, alu_zero  in  1  shared ALU outputs, same cycle.

Function
REQ-016 Requester N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-017 At most one grant per cycle; reqN_ready SHALL be combinational, equal to grant N.
REQ-018 Single eligible requester SHALL be granted; both eligible: grant the one not granted last (last_grant register).
REQ-019 last_grant SHALL update only on a grant; it is unchanged in idle cycles.
REQ-020 Granted request SHALL drive alu_a/alu_b/alu_ctrl in the grant cycle; no grant: all three driven to 0.
REQ-021 On grant N, alu_result, alu_zero and err SHALL load into response register N; rspN_valid=1 next cycle (latency 1).
REQ-022 err=1 when reqN_op not in {0000,0001,0010,0110,0111,1100}; op is still forwarded, response still produced.
REQ-023 rspN_valid SHALL clear after a cycle with rspN_valid=1 and rspN_ready=1 unless a new grant N occurs that cycle (then reload, stays 1).
REQ-024 Response register N SHALL hold value while rspN_valid=1 and rspN_ready=0; requester N not granted meanwhile.
REQ-025 rspN_ready while rspN_valid=0 SHALL have no effect.
REQ-026 Response registers SHALL be independent: stall on response 0 never blocks requester 1.
REQ-027 Both continuously eligible: grants SHALL strictly alternate (no starvation, max wait 1 cycle).
REQ-028 reqN_* inputs with reqN_valid=0 SHALL be ignored.

Reset
REQ-029 reset=0 SHALL immediately clear rsp0_valid, rsp1_valid, rsp*_err and last_grant=1 (requester 0 wins first tie).
REQ-030 During reset, req0_ready=req1_ready=0 and alu_a/alu_b/alu_ctrl=0; rsp*_result, rsp*_zero=0.
REQ-031 Reset mid-operation SHALL discard any unconsumed response; no response reappears after reset release.
REQ-032 First grant possible on the first rising edge with reset=1.

Verification
REQ-033 Single op: req0 a=5, b=3, op=0010 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, result=8, zero=0, err=0.
REQ-034 Tie after reset: both valid, req0 a=7,b=7,op=0110; req1 a=1,b=2,op=0001 -> cycle1 grant0 (result 0, zero=1), cycle2 grant1 (result 3).
REQ-035 Backpressure: rsp0_ready=0, rsp0_valid=1, req0 valid for 3 cycles -> req0_ready=0 throughout, rsp0_result stable; req1 still granted each cycle.
REQ-036 Back-to-back: rsp0_ready=1, req0 ops 0000 (a=0xF0,b=0x3C) then 1100 (a=0,b=0) -> results 0x30 then 0xFFFF_FFFF_FFFF_FFFF, rsp0_valid held 1.
REQ-037 Illegal op: req1 op=0011, a=9, b=4 -> rsp1_result=0, zero=1, err=1.
REQ-038 Reset mid-op: rsp1_valid=1 unconsumed, reset pulsed low between edges -> rsp1_valid=0 immediately, remains 0 after release until new grant.
